// File: rtl/truth_table_engine_pkg.sv
// Shared types for the truth-table engine: gate-function select, FSM state
// encoding and the reduction-combining helper used by the gate evaluator.
package gate_pkg;

    // Legal range of the gate input count.
    localparam int N_IN_MIN = 2;
    localparam int N_IN_MAX = 6;

    // Gate-function select. The encoding is fixed and visible on the op port.
    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_NAND   = 3'd1,
        OP_OR     = 3'd2,
        OP_NOR    = 3'd3,
        OP_XOR    = 3'd4,
        OP_XNOR   = 3'd5,
        OP_CONST0 = 3'd6,
        OP_CONST1 = 3'd7
    } gate_op_e;

    // Sweep controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } tte_state_e;

    // Combine the three basic reductions of an input vector into the
    // selected gate result. CONST0 is built as NOT(AND OR NAND) so that it
    // is a genuine function of the same reduction, which always yields 0.
    function automatic logic apply_op(input gate_op_e op,
                                      input logic     and_r,
                                      input logic     or_r,
                                      input logic     xor_r);
        logic res;
        case (op)
            OP_AND:    res = and_r;
            OP_NAND:   res = ~and_r;
            OP_OR:     res = or_r;
            OP_NOR:    res = ~or_r;
            OP_XOR:    res = xor_r;
            OP_XNOR:   res = ~xor_r;
            OP_CONST0: res = ~(and_r | ~and_r);
            OP_CONST1: res = 1'b1;
            default:   res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/truth_table_engine_if.sv
// Request/status bundle between a sweep requester (master) and the engine
// (slave). Suffixes are from the engine's point of view.
//
// Handshake: start_i is a level request. It is accepted on any rising edge
// where the engine is not sweeping (busy_o low); op_i is sampled only on that
// edge. While busy_o is high start_i and op_i are ignored. done_o is a single
// cycle pulse after the last row is written; table_o and ones_o are then
// stable until the next accepted start.
interface truth_table_engine_if #(
    parameter int N_IN = 2
);
    import gate_pkg::*;

    localparam int ROWS = 2 ** N_IN;

    logic              start_i;
    logic [2:0]        op_i;
    logic              busy_o;
    logic              done_o;
    logic [N_IN-1:0]   vec_o;
    logic              bit_out_o;
    logic [ROWS-1:0]   table_o;
    logic [N_IN:0]     ones_o;
    tte_state_e        state_o;

    // Requester side: drives the request, observes status and results.
    modport master (
        output start_i,
        output op_i,
        input  busy_o,
        input  done_o,
        input  vec_o,
        input  bit_out_o,
        input  table_o,
        input  ones_o,
        input  state_o
    );

    // Engine side.
    modport slave (
        input  start_i,
        input  op_i,
        output busy_o,
        output done_o,
        output vec_o,
        output bit_out_o,
        output table_o,
        output ones_o,
        output state_o
    );

endinterface

// File: rtl/truth_table_engine_gate_eval.sv
// Purely combinational N_IN-input gate: reduces the whole input vector with
// the selected function.
module gate_eval
    import gate_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  gate_op_e        op_i,
    input  logic [N_IN-1:0] vec_i,
    output logic            bit_o
);

    logic and_r;
    logic or_r;
    logic xor_r;

    // Basic reductions across every input bit.
    always_comb begin
        and_r = &vec_i;
        or_r  = |vec_i;
        xor_r = ^vec_i;
    end

    // Select the requested gate function from the reductions.
    always_comb begin
        bit_o = apply_op(op_i, and_r, or_r, xor_r);
    end

endmodule

// File: rtl/truth_table_engine.sv
// Truth-table engine: on request, walks every input vector of an N_IN-input
// gate, one per cycle, and records the gate result per row plus a count of
// ones. Holds the finished table until the next request.
module truth_table_engine
    import gate_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    truth_table_engine_if.slave   bus
);

    localparam int              ROWS     = 2 ** N_IN;
    localparam logic [N_IN-1:0] LAST_VEC = '1;
    localparam logic [N_IN-1:0] VEC_ONE  = {{(N_IN-1){1'b0}}, 1'b1};

    tte_state_e      state_q, state_d;
    gate_op_e        op_q, op_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [ROWS-1:0] table_q, table_d;
    logic [N_IN:0]   ones_q, ones_d;

    logic            accept;
    logic            last_row;
    logic            bit_out;
    logic            busy;
    logic            done;

    // A request is taken whenever no sweep is running, including the done
    // cycle, so back-to-back sweeps lose no cycle.
    assign accept   = bus.start_i && (state_q != ST_SWEEP);
    assign last_row = (vec_q == LAST_VEC);

    gate_eval #(
        .N_IN (N_IN)
    ) u_gate_eval (
        .op_i  (op_q),
        .vec_i (vec_q),
        .bit_o (bit_out)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                if (last_row) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = accept ? ST_SWEEP : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs, decoded directly from the state.
    always_comb begin
        busy = (state_q == ST_SWEEP);
        done = (state_q == ST_DONE);
    end

    // Datapath next-state: latch op and clear results on accept, otherwise
    // record one row per sweep cycle. vec stops on the last row.
    always_comb begin
        op_d    = op_q;
        vec_d   = vec_q;
        table_d = table_q;
        ones_d  = ones_q;
        if (accept) begin
            op_d    = gate_op_e'(bus.op_i);
            vec_d   = '0;
            table_d = '0;
            ones_d  = '0;
        end else if (state_q == ST_SWEEP) begin
            table_d[vec_q] = bit_out;
            // At most ROWS ones are added, which N_IN+1 bits always hold.
            ones_d = ones_q + {{N_IN{1'b0}}, bit_out};
            if (!last_row) begin
                vec_d = vec_q + VEC_ONE;
            end
        end
    end

    // Datapath registers; reset parks op on CONST0 so bit_out reads 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q    <= OP_CONST0;
            vec_q   <= '0;
            table_q <= '0;
            ones_q  <= '0;
        end else begin
            op_q    <= op_d;
            vec_q   <= vec_d;
            table_q <= table_d;
            ones_q  <= ones_d;
        end
    end

    // Drive the status bundle.
    always_comb begin
        bus.busy_o    = busy;
        bus.done_o    = done;
        bus.vec_o     = vec_q;
        bus.bit_out_o = bit_out;
        bus.table_o   = table_q;
        bus.ones_o    = ones_q;
        bus.state_o   = state_q;
    end

endmodule

// File: tb/tb_truth_table_engine.sv
`timescale 1ns/1ps
module tb_truth_table_engine;
  import gate_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  truth_table_engine_if #(.N_IN(2)) bus2();
  truth_table_engine_if #(.N_IN(3)) bus3();

  truth_table_engine #(.N_IN(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));
  truth_table_engine #(.N_IN(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

  int n_cmp;
  int n_bad;

  localparam int MAXK = 12;
  logic        obs_busy  [0:MAXK];
  logic        obs_done  [0:MAXK];
  logic        obs_bit   [0:MAXK];
  int          obs_vec   [0:MAXK];
  int          obs_ones  [0:MAXK];
  logic [63:0] obs_table [0:MAXK];

  // ---------------- reference model ----------------
  // Gate result from the number of ones in the row index.
  function automatic logic ref_bit(input logic [2:0] op, input int n, input int row);
    int pop;
    pop = $countones(row);
    case (op)
      3'd0: return (pop == n);
      3'd1: return (pop != n);
      3'd2: return (pop > 0);
      3'd3: return (pop == 0);
      3'd4: return ((pop % 2) == 1);
      3'd5: return ((pop % 2) == 0);
      3'd6: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [63:0] ref_table(input logic [2:0] op, input int n);
    logic [63:0] t;
    t = '0;
    for (int r = 0; r < (1 << n); r++) t[r] = ref_bit(op, n, r);
    return t;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_in(input int n, input logic s, input logic [2:0] op);
    if (n == 2) begin
      bus2.start_i = s;
      bus2.op_i    = op;
    end else begin
      bus3.start_i = s;
      bus3.op_i    = op;
    end
  endtask

  task automatic sample(input int n, input int k);
    if (n == 2) begin
      obs_busy[k]  = bus2.busy_o;
      obs_done[k]  = bus2.done_o;
      obs_bit[k]   = bus2.bit_out_o;
      obs_vec[k]   = int'(bus2.vec_o);
      obs_ones[k]  = int'(bus2.ones_o);
      obs_table[k] = 64'(bus2.table_o);
    end else begin
      obs_busy[k]  = bus3.busy_o;
      obs_done[k]  = bus3.done_o;
      obs_bit[k]   = bus3.bit_out_o;
      obs_vec[k]   = int'(bus3.vec_o);
      obs_ones[k]  = int'(bus3.ones_o);
      obs_table[k] = 64'(bus3.table_o);
    end
  endtask

  // Start a sweep at edge 0 and record cycles 1..ROWS+2. Optionally re-pulse
  // start with another op after sampling cycle poke_k. Called at posedge+1
  // with the engine idle; op is scrambled once the start has been taken.
  task automatic drive(input int n, input logic [2:0] op, input int poke_k, input logic [2:0] poke_op);
    int rows;
    rows = 1 << n;
    set_in(n, 1'b1, op);
    @(posedge clk); #1;
    set_in(n, 1'b0, 3'($urandom_range(0, 7)));
    for (int k = 1; k <= rows + 2; k++) begin
      sample(n, k);
      if (k == poke_k) set_in(n, 1'b1, poke_op);
      @(posedge clk); #1;
      if (k == poke_k) set_in(n, 1'b0, 3'($urandom_range(0, 7)));
    end
  endtask

  function automatic logic [15:0] busy_mask(input int rows);
    logic [15:0] m;
    m = '0;
    for (int k = 1; k <= rows + 2; k++) m[k] = obs_busy[k];
    return m;
  endfunction

  function automatic logic [15:0] done_mask(input int rows);
    logic [15:0] m;
    m = '0;
    for (int k = 1; k <= rows + 2; k++) m[k] = obs_done[k];
    return m;
  endfunction

  function automatic logic [63:0] bit_seq(input int rows);
    logic [63:0] s;
    s = '0;
    for (int k = 1; k <= rows; k++) s[k-1] = obs_bit[k];
    return s;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    set_in(2, 1'b0, 3'd0);
    set_in(3, 1'b0, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus2.busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus2.busy_o); end
    n_cmp++; if (bus2.done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus2.done_o); end
    n_cmp++; if (bus2.vec_o !== 2'd0) begin n_bad++; $display("FAIL reset_vec: got %0d want 0", bus2.vec_o); end
    n_cmp++; if (bus2.table_o !== 4'd0) begin n_bad++; $display("FAIL reset_table: got %b want 0000", bus2.table_o); end
    n_cmp++; if (bus2.ones_o !== 3'd0) begin n_bad++; $display("FAIL reset_ones: got %0d want 0", bus2.ones_o); end
    n_cmp++; if (bus2.bit_out_o !== 1'b0) begin n_bad++; $display("FAIL reset_bit_out: got %b want 0", bus2.bit_out_o); end
    n_cmp++; if (bus2.state_o !== ST_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", bus2.state_o, ST_IDLE); end
    n_cmp++; if (bus3.table_o !== 8'd0 || bus3.ones_o !== 4'd0) begin n_bad++; $display("FAIL reset_n3: got table %b ones %0d want 0/0", bus3.table_o, bus3.ones_o); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_and();
    drive(2, OP_AND, 0, 3'd0);
    n_cmp++; if (busy_mask(4) !== 16'h001e) begin n_bad++; $display("FAIL and_busy_cycles: got %h want 001e", busy_mask(4)); end
    n_cmp++; if (done_mask(4) !== 16'h0020) begin n_bad++; $display("FAIL and_done_cycle: got %h want 0020", done_mask(4)); end
    n_cmp++; if (obs_table[5] !== 64'b1000) begin n_bad++; $display("FAIL and_table: got %b want 1000", obs_table[5][3:0]); end
    n_cmp++; if (obs_ones[5] != 1) begin n_bad++; $display("FAIL and_ones: got %0d want 1", obs_ones[5]); end
    n_cmp++; if (bit_seq(4) !== ref_table(OP_AND, 2)) begin n_bad++; $display("FAIL and_bit_out_seq: got %b want %b", bit_seq(4)[3:0], ref_table(OP_AND, 2)); end
    n_cmp++; if (obs_vec[1] != 0 || obs_vec[2] != 1 || obs_vec[3] != 2 || obs_vec[4] != 3 || obs_vec[5] != 3) begin
      n_bad++; $display("FAIL and_vec_seq: got %0d %0d %0d %0d %0d want 0 1 2 3 3", obs_vec[1], obs_vec[2], obs_vec[3], obs_vec[4], obs_vec[5]);
    end
  endtask

  task automatic test_const0();
    logic any_one;
    drive(2, OP_CONST0, 0, 3'd0);
    any_one = 1'b0;
    for (int k = 1; k <= 5; k++) any_one = any_one | obs_bit[k];
    n_cmp++; if (obs_table[5] !== 64'd0) begin n_bad++; $display("FAIL const0_table: got %b want 0000", obs_table[5][3:0]); end
    n_cmp++; if (obs_ones[5] != 0) begin n_bad++; $display("FAIL const0_ones: got %0d want 0", obs_ones[5]); end
    n_cmp++; if (any_one !== 1'b0) begin n_bad++; $display("FAIL const0_bit_out: got %b want 0", any_one); end
  endtask

  task automatic test_n3();
    drive(3, OP_XOR, 0, 3'd0);
    n_cmp++; if (obs_table[9] !== 64'b10010110) begin n_bad++; $display("FAIL n3_xor_table: got %b want 10010110", obs_table[9][7:0]); end
    n_cmp++; if (obs_ones[9] != 4) begin n_bad++; $display("FAIL n3_xor_ones: got %0d want 4", obs_ones[9]); end
    n_cmp++; if (busy_mask(8) !== 16'h01fe || done_mask(8) !== 16'h0200) begin
      n_bad++; $display("FAIL n3_xor_timing: got busy %h done %h want 01fe 0200", busy_mask(8), done_mask(8));
    end
    drive(3, OP_NOR, 0, 3'd0);
    n_cmp++; if (obs_table[9] !== 64'b00000001) begin n_bad++; $display("FAIL n3_nor_table: got %b want 00000001", obs_table[9][7:0]); end
    n_cmp++; if (obs_ones[9] != 1) begin n_bad++; $display("FAIL n3_nor_ones: got %0d want 1", obs_ones[9]); end
  endtask

  task automatic test_ignore_start();
    drive(2, OP_OR, 2, OP_AND);
    n_cmp++; if (obs_table[5] !== 64'b1110) begin n_bad++; $display("FAIL ignore_table: got %b want 1110", obs_table[5][3:0]); end
    n_cmp++; if (obs_ones[5] != 3) begin n_bad++; $display("FAIL ignore_ones: got %0d want 3", obs_ones[5]); end
    n_cmp++; if (busy_mask(4) !== 16'h001e || done_mask(4) !== 16'h0020) begin
      n_bad++; $display("FAIL ignore_timing: got busy %h done %h want 001e 0020", busy_mask(4), done_mask(4));
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    logic found;
    set_in(2, 1'b1, OP_CONST1);
    @(posedge clk); #1;
    set_in(2, 1'b0, OP_AND);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (bus2.busy_o !== 1'b1 || bus2.table_o !== 4'b0011 || bus2.ones_o !== 3'd2) begin
      n_bad++; $display("FAIL mid_partial: got busy %b table %b ones %0d want 1 0011 2", bus2.busy_o, bus2.table_o, bus2.ones_o);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (bus2.busy_o !== 1'b0 || bus2.done_o !== 1'b0) begin n_bad++; $display("FAIL mid_reset_flags: got busy %b done %b want 0 0", bus2.busy_o, bus2.done_o); end
    n_cmp++; if (bus2.table_o !== 4'd0 || bus2.ones_o !== 3'd0) begin n_bad++; $display("FAIL mid_reset_results: got table %b ones %0d want 0000 0", bus2.table_o, bus2.ones_o); end
    n_cmp++; if (bus2.vec_o !== 2'd0 || bus2.bit_out_o !== 1'b0) begin n_bad++; $display("FAIL mid_reset_vec: got vec %0d bit %b want 0 0", bus2.vec_o, bus2.bit_out_o); end
    #2 reset = 1'b0;
    dones = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus2.done_o === 1'b1) dones++;
    end
    n_cmp++; if (dones != 0 || bus2.table_o !== 4'd0) begin n_bad++; $display("FAIL mid_no_done: got dones %0d table %b want 0 0000", dones, bus2.table_o); end
    // First start right after reset release must be taken on the first edge.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    set_in(2, 1'b1, OP_OR);
    @(posedge clk); #1;
    set_in(2, 1'b0, OP_NAND);
    n_cmp++; if (bus2.busy_o !== 1'b1 || bus2.vec_o !== 2'd0) begin n_bad++; $display("FAIL post_reset_start: got busy %b vec %0d want 1 0", bus2.busy_o, bus2.vec_o); end
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus2.done_o === 1'b1) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_cmp++; if (found !== 1'b1 || bus2.table_o !== 4'b1110) begin n_bad++; $display("FAIL post_reset_sweep: got done %b table %b want 1 1110", found, bus2.table_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_restart();
    logic found;
    int   busy_cnt;
    set_in(2, 1'b1, OP_OR);
    @(posedge clk); #1;
    set_in(2, 1'b0, OP_OR);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus2.done_o === 1'b1) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_cmp++; if (found !== 1'b1 || bus2.table_o !== 4'b1110) begin n_bad++; $display("FAIL restart_first: got done %b table %b want 1 1110", found, bus2.table_o); end
    set_in(2, 1'b1, OP_NAND);
    @(posedge clk); #1;
    set_in(2, 1'b0, OP_AND);
    n_cmp++; if (bus2.busy_o !== 1'b1 || bus2.done_o !== 1'b0) begin n_bad++; $display("FAIL restart_begin: got busy %b done %b want 1 0", bus2.busy_o, bus2.done_o); end
    n_cmp++; if (bus2.table_o !== 4'd0 || bus2.ones_o !== 3'd0 || bus2.vec_o !== 2'd0) begin
      n_bad++; $display("FAIL restart_cleared: got table %b ones %0d vec %0d want 0000 0 0", bus2.table_o, bus2.ones_o, bus2.vec_o);
    end
    busy_cnt = 1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus2.done_o === 1'b1) begin found = 1'b1; break; end
      if (bus2.busy_o === 1'b1) busy_cnt++;
    end
    n_cmp++; if (found !== 1'b1 || busy_cnt != 4) begin n_bad++; $display("FAIL restart_timing: got done %b busy %0d want 1 4", found, busy_cnt); end
    n_cmp++; if (bus2.table_o !== 4'b0111 || bus2.ones_o !== 3'd3) begin n_bad++; $display("FAIL restart_result: got table %b ones %0d want 0111 3", bus2.table_o, bus2.ones_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int          n, rows, poke_k, exp_ones;
    logic [2:0]  op, poke_op;
    logic [63:0] exp_t;
    logic [15:0] exp_busy, exp_done;
    for (int it = 0; it < 16; it++) begin
      n        = (($urandom_range(0, 1)) == 0) ? 2 : 3;
      rows     = 1 << n;
      op       = 3'($urandom_range(0, 7));
      poke_op  = 3'($urandom_range(0, 7));
      poke_k   = int'($urandom_range(0, rows));
      exp_t    = ref_table(op, n);
      exp_ones = $countones(exp_t);
      exp_busy = 16'(((1 << rows) - 1) << 1);
      exp_done = 16'(1 << (rows + 1));
      drive(n, op, poke_k, poke_op);
      n_cmp++; if (obs_table[rows+1] !== exp_t) begin n_bad++; $display("FAIL rand_table n=%0d op=%0d: got %h want %h", n, op, obs_table[rows+1], exp_t); end
      n_cmp++; if (obs_ones[rows+1] != exp_ones) begin n_bad++; $display("FAIL rand_ones n=%0d op=%0d: got %0d want %0d", n, op, obs_ones[rows+1], exp_ones); end
      n_cmp++; if (obs_table[rows+2] !== exp_t || obs_ones[rows+2] != exp_ones) begin
        n_bad++; $display("FAIL rand_hold n=%0d op=%0d: got %h/%0d want %h/%0d", n, op, obs_table[rows+2], obs_ones[rows+2], exp_t, exp_ones);
      end
      n_cmp++; if (bit_seq(rows) !== exp_t) begin n_bad++; $display("FAIL rand_bit_out n=%0d op=%0d: got %h want %h", n, op, bit_seq(rows), exp_t); end
      n_cmp++; if (busy_mask(rows) !== exp_busy || done_mask(rows) !== exp_done) begin
        n_bad++; $display("FAIL rand_timing n=%0d: got busy %h done %h want %h %h", n, busy_mask(rows), done_mask(rows), exp_busy, exp_done);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    set_in(2, 1'b0, 3'd0);
    set_in(3, 1'b0, 3'd0);
    test_reset();
    test_and();
    test_const0();
    test_n3();
    test_ignore_start();
    test_reset_mid();
    test_restart();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 ns want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/truth_table_engine.md
TRUTH_TABLE_ENGINE -- requirements
Module: truth_table_engine

Interface
REQ-001 The block SHALL have parameter N_IN, default 2, legal range 2..6, giving the number of gate inputs.
REQ-002 The block SHALL have derived constant ROWS = 2**N_IN, giving the truth-table size.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit, a request to begin a sweep.
REQ-006 The block SHALL have port op, input, 3 bits, the gate-function select, sampled only when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit, high while a sweep is in progress.
REQ-008 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking a completed sweep.
REQ-009 The block SHALL have port vec, output, N_IN bits, the input vector currently applied.
REQ-010 The block SHALL have port bit_out, output, 1 bit, the gate result for vec (combinational from vec and latched op).
REQ-011 The block SHALL have port table, output, ROWS bits; bit i is the result for input vector i.
REQ-012 The block SHALL have port ones, output, N_IN+1 bits, the count of 1 results in table.

Function
REQ-013 op encoding SHALL be fixed: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR (odd parity), 5 XNOR, 6 CONST0 (NOT(AND OR NAND)), 7 CONST1.
REQ-014 Each op SHALL be applied as a reduction across all N_IN bits of vec.
REQ-015 The FSM SHALL have three states, IDLE, SWEEP and DONE, and reset SHALL enter IDLE.
REQ-016 In IDLE or DONE, start=1 SHALL be accepted: latch op, clear table and ones, set vec=0, and enter SWEEP on the next edge.
REQ-017 In SWEEP, each cycle SHALL write table[vec] <= bit_out, add bit_out to ones, and increment vec.
REQ-018 In SWEEP, when vec equals ROWS-1, the FSM SHALL write the last entry and enter DONE instead of incrementing; vec SHALL hold ROWS-1.
REQ-019 busy SHALL be 1 exactly in SWEEP, for ROWS consecutive cycles.
REQ-020 done SHALL be 1 exactly in DONE, for one cycle, and then return to IDLE unless start is accepted in that cycle.
REQ-021 Latency: start sampled at edge t SHALL give busy in cycles t+1..t+ROWS and done in cycle t+ROWS+1.
REQ-022 start asserted during SWEEP SHALL be ignored, and changes to op during SWEEP SHALL have no effect.
REQ-023 table and ones SHALL hold their final values from DONE until the next accepted start.
REQ-024 ones SHALL never wrap; its maximum is ROWS, which N_IN+1 bits hold.

Reset
REQ-025 On reset assertion, the block SHALL asynchronously set: state IDLE; busy=0; done=0; vec=0; table=0; ones=0; latched op=CONST0 (so bit_out=0).
REQ-026 Reset asserted mid-sweep SHALL abort the sweep, raise no done pulse, and discard partial table contents.
REQ-027 After reset deasserts, the first start SHALL be accepted at the first rising edge.

Structure
REQ-028 Package gate_pkg SHALL hold the op enumeration (3-bit typedef) and the FSM state typedef.
REQ-029 Sub-module gate_eval SHALL provide purely combinational reduction: inputs op and an N_IN-bit vector, output 1 bit; it is parameterised by N_IN.
REQ-030 The top level SHALL contain only the FSM, the vec counter, the table register and the ones counter.

Verification
REQ-031 N_IN=2, op=AND, start pulsed at edge 0 -> busy cycles 1-4, done in cycle 5 only, table=4'b1000, ones=1.
REQ-032 N_IN=2, op=CONST0 -> table=4'b0000, ones=0, bit_out=0 throughout the sweep.
REQ-033 N_IN=3, op=XOR -> table=8'b10010110, ones=4; op=NOR -> table=8'b00000001, ones=1.
REQ-034 N_IN=2, op=OR started, start re-pulsed and op changed to AND in busy cycle 2 -> ignored; table=4'b1110, done at cycle 5.
REQ-035 Reset asserted in busy cycle 3, then released -> busy=0, done=0, table=0, ones=0, vec=0 immediately; no done pulse.
REQ-036 start held during the done cycle with op=NAND -> the new sweep begins next cycle; table cleared, final table=4'b0111, ones=3.
